// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared width default and ramp state encoding for pwm control blocks
package pwm_ctrl_pkg;

   localparam int PWM_WIDTH = 12;

   typedef enum logic [1:0] {
      ST_HOLD      = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_RAMP_DOWN = 2'd2,
      ST_KICK      = 2'd3
   } ramp_state_t;

endpackage

// File: rtl/pwm_ramp_ctrl_tick_gen.sv
// rtl/pwm_ramp_ctrl_tick_gen.sv - rate prescaler, one tick every DIV cycles while run=1
module tick_gen #(
   parameter int DIV = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = run && (cnt == LAST);

   // Any pause in run restarts the interval so the next tick is a full DIV cycles away.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (!run) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - soft-start/soft-stop slew of the pwm compare value; PWM_RAMP_KICK_EN adds a kick phase
module pwm_ramp_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int WIDTH      = PWM_WIDTH,
   parameter int STEP       = 16,
   parameter int STEP_DIV   = 1024,
   parameter int KICK_DUTY  = 1024,
   parameter int KICK_TICKS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] target,
   input  logic             target_load,
   output logic [WIDTH-1:0] compare,
   output logic             busy,
   output logic             at_target
);

   if (STEP_DIV < 1 || STEP < 1 || KICK_TICKS < 1 || KICK_DUTY >= (1 << WIDTH)) begin : g_cfg_err
      $error("pwm_ramp_ctrl: invalid parameter set");
   end

   ramp_state_t      state;
   logic [WIDTH-1:0] target_q;
   logic [WIDTH-1:0] goal;
   logic [WIDTH-1:0] up_val;
   logic [WIDTH-1:0] down_val;
   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;
   logic             tick;

   assign goal      = en ? target_q : '0;
   assign at_target = (compare == goal);

   // One extra bit keeps the saturating step honest at both ends of the range.
   assign sum_w    = {1'b0, compare} + (WIDTH+1)'(STEP);
   assign diff_w   = {1'b0, compare} - (WIDTH+1)'(STEP);
   assign up_val   = (sum_w > {1'b0, goal}) ? goal : sum_w[WIDTH-1:0];
   assign down_val = (diff_w[WIDTH] || (diff_w[WIDTH-1:0] < goal)) ? goal : diff_w[WIDTH-1:0];

   tick_gen #(
      .DIV (STEP_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .run  (state != ST_HOLD),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         target_q <= '0;
      end else if (target_load) begin
         target_q <= target;
      end
   end

`ifdef PWM_RAMP_KICK_EN
   localparam int KW = (KICK_TICKS > 1) ? $clog2(KICK_TICKS) : 1;
   localparam logic [KW-1:0] KICK_LAST = KW'(KICK_TICKS - 1);

   logic [KW-1:0] kick_cnt;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_HOLD;
         compare <= '0;
         busy    <= 1'b0;
`ifdef PWM_RAMP_KICK_EN
         kick_cnt <= '0;
`endif
      end else begin
         case (state)
            ST_HOLD: begin
`ifdef PWM_RAMP_KICK_EN
               if ((compare == '0) && (goal != '0)) begin
                  state    <= ST_KICK;
                  compare  <= WIDTH'(KICK_DUTY);
                  kick_cnt <= '0;
                  busy     <= 1'b1;
               end else
`endif
               if (goal > compare) begin
                  state <= ST_RAMP_UP;
                  busy  <= 1'b1;
               end else if (goal < compare) begin
                  state <= ST_RAMP_DOWN;
                  busy  <= 1'b1;
               end
            end
            // A reversed goal only turns the ramp around; the prescaler keeps its phase.
            ST_RAMP_UP: begin
               if (goal < compare) begin
                  state <= ST_RAMP_DOWN;
               end else if (goal == compare) begin
                  state <= ST_HOLD;
                  busy  <= 1'b0;
               end else if (tick) begin
                  compare <= up_val;
               end
            end
            ST_RAMP_DOWN: begin
               if (goal > compare) begin
                  state <= ST_RAMP_UP;
               end else if (goal == compare) begin
                  state <= ST_HOLD;
                  busy  <= 1'b0;
               end else if (tick) begin
                  compare <= down_val;
               end
            end
`ifdef PWM_RAMP_KICK_EN
            ST_KICK: begin
               if (goal == '0) begin
                  state <= ST_RAMP_DOWN;
               end else if (tick) begin
                  if (kick_cnt == KICK_LAST) begin
                     if (goal > compare) begin
                        state <= ST_RAMP_UP;
                     end else if (goal < compare) begin
                        state <= ST_RAMP_DOWN;
                     end else begin
                        state <= ST_HOLD;
                        busy  <= 1'b0;
                     end
                  end else begin
                     kick_cnt <= kick_cnt + 1'b1;
                  end
               end
            end
`endif
            default: begin
               state <= ST_HOLD;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - vector table, directed corners and random run against a reference model
module tb_pwm_ramp_ctrl;

   localparam int W      = 12;
   localparam int STEP   = 16;
   localparam int DIV    = 4;
   localparam int KDUTY  = 64;
   localparam int KTICKS = 2;
   localparam int MAXV   = (1 << W) - 1;
`ifdef PWM_RAMP_KICK_EN
   localparam bit KICK_ON = 1'b1;
`else
   localparam bit KICK_ON = 1'b0;
`endif
   localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_KICK = 3;

   logic         clk;
   logic         rst;
   logic         en;
   logic [W-1:0] target;
   logic         target_load;
   logic [W-1:0] compare;
   logic         busy;
   logic         at_target;

   pwm_ramp_ctrl #(
      .WIDTH      (W),
      .STEP       (STEP),
      .STEP_DIV   (DIV),
      .KICK_DUTY  (KDUTY),
      .KICK_TICKS (KTICKS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .target      (target),
      .target_load (target_load),
      .compare     (compare),
      .busy        (busy),
      .at_target   (at_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit en;
      bit load;
      int target;
      int cycles;
      int exp_cmp;
      bit exp_busy;
      bit exp_at;
   } vec_t;

   vec_t tbl[$];
   int   n_vec;
   int   n_bad;

   // Reference model: compare value, latched target, ramp mode, cycles into the current step interval.
   int m_cmp, m_tq, m_mode, m_pre, m_kick;
   bit m_busy;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_cmp = 0; m_tq = 0; m_mode = M_IDLE; m_pre = 0; m_kick = 0; m_busy = 0;
   endtask

   task automatic model_edge();
      int goal, ncmp, nmode;
      bit tk;
      goal  = en ? m_tq : 0;
      tk    = (m_mode != M_IDLE) && (m_pre == DIV - 1);
      ncmp  = m_cmp;
      nmode = m_mode;
      if (m_mode == M_IDLE) begin
         if (KICK_ON && m_cmp == 0 && goal > 0) begin
            nmode = M_KICK; ncmp = KDUTY; m_kick = 0;
         end else if (goal > m_cmp) nmode = M_UP;
         else if (goal < m_cmp) nmode = M_DOWN;
      end else if (m_mode == M_KICK) begin
         if (goal == 0) nmode = M_DOWN;
         else if (tk) begin
            m_kick++;
            if (m_kick == KTICKS)
               nmode = (goal > m_cmp) ? M_UP : (goal < m_cmp) ? M_DOWN : M_IDLE;
         end
      end else if (goal == m_cmp) begin
         nmode = M_IDLE;
      end else if ((goal > m_cmp) != (m_mode == M_UP)) begin
         nmode = (goal > m_cmp) ? M_UP : M_DOWN;
      end else if (tk) begin
         if (m_mode == M_UP) ncmp = (m_cmp + STEP > goal) ? goal : m_cmp + STEP;
         else                ncmp = (m_cmp - STEP < goal) ? goal : m_cmp - STEP;
      end
      m_pre  = (m_mode == M_IDLE) ? 0 : (m_pre + 1) % DIV;
      m_cmp  = ncmp;
      m_mode = nmode;
      m_busy = (nmode != M_IDLE);
      if (target_load) m_tq = target;
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check("model_compare", int'(compare), m_cmp);
      check("model_busy", int'(busy), int'(m_busy));
      check("model_at_target", int'(at_target), int'(m_cmp == (en ? m_tq : 0)));
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst = 1'b0; en = 1'b0; target = '0; target_load = 1'b0;
      model_reset();

`ifdef PWM_RAMP_KICK_EN
      tbl.push_back('{1, 1, 200,  1,   0, 0, 0});
      tbl.push_back('{1, 0,   0,  1,  64, 1, 0});
      tbl.push_back('{1, 0,   0,  8,  64, 1, 0});
      tbl.push_back('{1, 0,   0,  4,  80, 1, 0});
      tbl.push_back('{1, 0,   0, 32, 200, 1, 1});
      tbl.push_back('{1, 0,   0,  1, 200, 0, 1});
      tbl.push_back('{0, 0,   0,  1, 200, 1, 0});
      tbl.push_back('{0, 0,   0, 52,   0, 1, 1});
      tbl.push_back('{0, 0,   0,  1,   0, 0, 1});
      tbl.push_back('{0, 1,  30,  1,   0, 0, 1});
      tbl.push_back('{1, 0,   0,  1,  64, 1, 0});
      tbl.push_back('{1, 0,   0,  8,  64, 1, 0});
      tbl.push_back('{1, 0,   0,  4,  48, 1, 0});
      tbl.push_back('{1, 0,   0,  4,  32, 1, 0});
      tbl.push_back('{1, 0,   0,  4,  30, 1, 1});
      tbl.push_back('{1, 0,   0,  1,  30, 0, 1});
`else
      tbl.push_back('{1, 1,  100,    1,    0, 0, 0});
      tbl.push_back('{1, 0,    0,    1,    0, 1, 0});
      tbl.push_back('{1, 0,    0,    4,   16, 1, 0});
      tbl.push_back('{1, 0,    0,    3,   16, 1, 0});
      tbl.push_back('{1, 0,    0,    1,   32, 1, 0});
      tbl.push_back('{1, 0,    0,   16,   96, 1, 0});
      tbl.push_back('{1, 0,    0,    4,  100, 1, 1});
      tbl.push_back('{1, 0,    0,    1,  100, 0, 1});
      tbl.push_back('{0, 0,    0,    1,  100, 1, 0});
      tbl.push_back('{0, 0,    0,    4,   84, 1, 0});
      tbl.push_back('{0, 0,    0,   20,    4, 1, 0});
      tbl.push_back('{0, 0,    0,    4,    0, 1, 1});
      tbl.push_back('{0, 0,    0,    1,    0, 0, 1});
      tbl.push_back('{1, 1,  100,    1,    0, 1, 0});
      tbl.push_back('{1, 0,    0,   12,   48, 1, 0});
      tbl.push_back('{1, 1,   20,    1,   48, 1, 0});
      tbl.push_back('{1, 0,    0,    3,   32, 1, 0});
      tbl.push_back('{1, 0,    0,    4,   20, 1, 1});
      tbl.push_back('{1, 0,    0,    1,   20, 0, 1});
      tbl.push_back('{1, 1, 4090,    1,   20, 0, 0});
      tbl.push_back('{1, 0,    0, 1021, 4090, 1, 1});
      tbl.push_back('{1, 0,    0,    1, 4090, 0, 1});
      tbl.push_back('{1, 1, 4095,    1, 4090, 0, 0});
      tbl.push_back('{1, 0,    0,    5, 4095, 1, 1});
      tbl.push_back('{1, 0,    0,    1, 4095, 0, 1});
      tbl.push_back('{1, 1,    0,    1, 4095, 0, 0});
      tbl.push_back('{1, 0,    0,    5, 4079, 1, 0});
`endif

      repeat (2) @(posedge clk);
      #1;
      check("reset_compare", int'(compare), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_at_target", int'(at_target), 1);
      rst = 1'b1;

      foreach (tbl[i]) begin
         en          = tbl[i].en;
         target_load = tbl[i].load;
         target      = W'(tbl[i].target);
         for (int c = 0; c < tbl[i].cycles; c++) begin
            cycle();
            target_load = 1'b0;
         end
         check($sformatf("row%0d_compare", i), int'(compare), tbl[i].exp_cmp);
         check($sformatf("row%0d_busy", i), int'(busy), int'(tbl[i].exp_busy));
         check($sformatf("row%0d_at_target", i), int'(at_target), int'(tbl[i].exp_at));
      end

      // Reset asserted between edges while a ramp is in flight.
      en = 1'b1; target = W'(500); target_load = 1'b1;
      cycle();
      target_load = 1'b0;
      repeat (10) cycle();
      #2 rst = 1'b0;
      #1;
      check("async_reset_compare", int'(compare), 0);
      check("async_reset_busy", int'(busy), 0);
      check("async_reset_at_target", int'(at_target), 1);
      model_reset();
      rst = 1'b1;

      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 39) == 0) begin
            target_load = 1'b1;
            case ($urandom_range(0, 3))
               0:       target = W'(MAXV);
               1:       target = W'($urandom_range(0, 63));
               default: target = W'($urandom_range(0, MAXV));
            endcase
         end
         if ($urandom_range(0, 149) == 0) en = ~en;
         cycle();
         target_load = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
